btb_array: RTL and testbench
============================

Name: btb_array

Overview:
- Parametrised 1R1W synchronous storage array for the branch target buffer. It is the successor to the fixed 16x56 single-port BTB macro.
- Separate read and write ports, per-lane write mask, and a per-entry valid bit.
- Hardware clear sequencer that invalidates every entry after reset or on a flush request.
- Sits between the fetch-stage BTB lookup logic (read port) and the branch-resolution update path (write port).

Parameters:
- DATA_WIDTH, 56, bits per entry.
- ADDR_WIDTH, 4, index bits.
- DEPTH, 1<<ADDR_WIDTH, number of entries (derived; not overridden independently).
- LANE_WIDTH, 8, write-mask granularity in bits. DATA_WIDTH % LANE_WIDTH must equal 0.
- NUM_LANES, DATA_WIDTH/LANE_WIDTH, write-mask width (derived).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  request to invalidate all entries
- ready  output  1  array accepts reads and writes
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read index
- rd_valid  output  1  read response strobe
- rd_data  output  DATA_WIDTH  read data
- rd_hit  output  1  valid bit of the read entry
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write index
- wr_data  input  DATA_WIDTH  write data
- wr_mask  input  NUM_LANES  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH]

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: ready=0, rd_valid=0, rd_hit=0, rd_data=0.
  - All valid bits cleared. Clear counter=0. State=CLEAR.
  - Data storage is not reset.
- CLEAR state:
  - Each cycle clears valid[cnt] and increments cnt.
  - Valid bits are already cleared by reset; CLEAR still walks all DEPTH entries, so the flush and reset paths behave identically.
  - When cnt==DEPTH-1 is cleared, the next state is READY and cnt wraps to 0.
  - Duration is exactly DEPTH cycles; ready rises in the cycle after the last clear.
- READY state: ready=1. Reads and writes are accepted only when ready=1; rd_en and wr_en are ignored in CLEAR.
- flush:
  - Sampled high in READY: rd_en and wr_en in the same cycle are dropped, and the next state is CLEAR with cnt=0.
  - Sampled high in CLEAR: restarts cnt at 0.
  - A read accepted in the cycle before the flush still returns its response, with pre-flush data and hit.
- Read:
  - Latency 1. rd_en accepted at edge t gives rd_valid=1 for the cycle after t, with rd_data=mem[rd_addr] and rd_hit=valid[rd_addr].
  - rd_valid is a single-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.
  - rd_data and rd_hit hold their last values when no read is accepted.
- Write:
  - Lanes with wr_mask[i]=1 are updated; the others are preserved.
  - valid[wr_addr] is set if any mask bit is set.
  - wr_en with wr_mask all zero is a no-op and does not set valid.
- Read/write collision (same cycle, rd_addr==wr_addr, both accepted) is write-first:
  - rd_data is the merged word: new lanes where the mask is set, old contents elsewhere.
  - rd_hit reflects the post-write valid, i.e. 1 if any mask bit is set, else the old valid.
- Different addresses: fully independent; both complete in the same cycle.
- Mid-operation reset: the pending read response is lost (rd_valid=0), the array returns to CLEAR, and writes are not applied.

Decomposition:
- Package btb_array_pkg contains:
  - typedef clr_state_t {CLR_CLEAR, CLR_READY};
  - a function for lane-mask merge (old, new, mask) -> merged word, used both by the write path and the collision bypass.
- One sub-module: btb_array_clear_fsm.
  - Contains the state register, clear counter, and flush handling.
  - Outputs ready, clr_en and clr_addr to the parent, which owns the data array and valid vector.

Test Plan:
- Reset release: ready=0 for exactly 16 cycles. ready=1 in cycle 17. Then a read of addr 3 gives rd_valid=1 one cycle later with rd_hit=0.
- Full write then read: wr addr 5, data 56'h12_3456_789A_BCDE, mask 7'h7F. Next-cycle read of addr 5 gives rd_data 56'h12_3456_789A_BCDE and rd_hit=1.
- Partial mask: write addr 5 with data 56'hFF_FFFF_FFFF_FFFF, mask 7'b0000001, then read addr 5. Required rd_data is 56'h12_3456_789A_BCFF.
- Collision: in a single cycle, rd and wr to addr 9 (previously 56'h0, valid=0) with data 56'hAA_AAAA_AAAA_AAAA and mask 7'b1100000. Required rd_data is 56'hAA_AA00_0000_0000 and rd_hit=1.
- Flush:
  - Populate addrs 0-15.
  - Assert flush with a simultaneous wr to addr 2: the write is dropped and ready=0 for 16 cycles.
  - Afterwards, all reads give rd_hit=0.
  - A read issued one cycle before the flush returns rd_hit=1.
- Flush during clear plus async reset:
  - Flush at clear cycle 8 extends the clear to 16 more cycles (ready rises 25 cycles after the first release).
  - Assert rst_n=0 mid-cycle, with a read pending: ready, rd_valid and rd_hit go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/btb_array_pkg.sv
// btb_array_pkg
//   Shared types and helpers for the branch target buffer storage array.
//   - clr_state_t : state of the clear sequencer (walking entries vs. serving).
//   - mergeLanes  : lane-masked merge of an old and a new entry word. It works on
//                   a wide container so any DATA_WIDTH/LANE_WIDTH pairing up to
//                   BTB_MAX_DATA_WIDTH can share one implementation. Callers
//                   zero-extend their operands and truncate the result.
package btb_array_pkg;

  typedef enum logic {
    CLR_CLEAR,
    CLR_READY
  } clr_state_t;

  localparam int BTB_MAX_DATA_WIDTH = 256;

  // Build a per-bit select mask by replicating each lane-enable bit across its
  // lane, then take new bits where selected and old bits elsewhere. Shifts are
  // used instead of variable bit indexing so the helper stays width-agnostic.
  function automatic logic [BTB_MAX_DATA_WIDTH-1:0] mergeLanes(
    input logic [BTB_MAX_DATA_WIDTH-1:0] oldWord,
    input logic [BTB_MAX_DATA_WIDTH-1:0] newWord,
    input logic [BTB_MAX_DATA_WIDTH-1:0] laneMask,
    input int                            laneWidth
  );
    logic [BTB_MAX_DATA_WIDTH-1:0] laneOnes;
    logic [BTB_MAX_DATA_WIDTH-1:0] bitSel;
    logic [BTB_MAX_DATA_WIDTH-1:0] maskShift;
    laneOnes  = (BTB_MAX_DATA_WIDTH'(1) << laneWidth) - BTB_MAX_DATA_WIDTH'(1);
    bitSel    = '0;
    maskShift = laneMask;
    for (int l = 0; l < BTB_MAX_DATA_WIDTH; l++) begin
      if (maskShift[0]) begin
        bitSel = bitSel | (laneOnes << (l * laneWidth));
      end
      maskShift = maskShift >> 1;
    end
    return (oldWord & ~bitSel) | (newWord & bitSel);
  endfunction

endpackage

// File: rtl/btb_array_clear_fsm.sv
// btb_array_clear_fsm
//   Clear sequencer for the BTB array. After reset, or on a flush, it walks
//   every index once, asking the parent to drop that entry's valid bit, then
//   reports the array as ready.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset (enters the clear walk)
//   flush_i    - restart the clear walk from index 0
//   ready_o    - array is serving reads and writes
//   clr_en_o   - valid bit at clr_addr_o must be cleared this cycle
//   clr_addr_o - index being cleared
module btb_array_clear_fsm
  import btb_array_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and counter registers; reset always starts a fresh walk from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A flush during the walk still clears the current index
  // but restarts the count, so the array is never reported ready before a full
  // DEPTH-cycle pass has completed after the most recent flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLR_CLEAR: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = CLR_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLR_READY: begin
        if (flush_i) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLR_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_o    = (state_q == CLR_READY);
  assign clr_en_o   = (state_q == CLR_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/btb_array.sv
// btb_array
//   1R1W synchronous storage for the branch target buffer with per-lane write
//   masking, a per-entry valid bit and a hardware clear sequencer.
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   flush              - invalidate every entry (drops same-cycle requests)
//   ready              - reads and writes are accepted
//   rd_en, rd_addr     - read request, index
//   rd_valid           - one-cycle response strobe, one cycle after the request
//   rd_data, rd_hit    - entry contents and its valid bit (held between reads)
//   wr_en, wr_addr     - write request, index
//   wr_data, wr_mask   - write word and per-lane enables
module btb_array
  import btb_array_pkg::*;
#(
  parameter  int DATA_WIDTH = 56,
  parameter  int ADDR_WIDTH = 4,
  parameter  int LANE_WIDTH = 8,
  localparam int DEPTH      = 1 << ADDR_WIDTH,
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_mask
);

  if ((DATA_WIDTH % LANE_WIDTH) != 0 || DATA_WIDTH > BTB_MAX_DATA_WIDTH) begin : gBadCfg
    $error("btb_array: DATA_WIDTH must be a multiple of LANE_WIDTH and fit the merge helper");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic                  rdValid_q;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  rdHit_q, rdHit_d;

  logic                  clrEn;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  rdAcc, wrAcc, wrApply, collide;
  logic [DATA_WIDTH-1:0] wrMerged;

  btb_array_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uClearFsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .ready_o   (ready),
    .clr_en_o  (clrEn),
    .clr_addr_o(clrAddr)
  );

  // A flush takes priority over any same-cycle request, and nothing is
  // accepted while the clear walk runs. An all-zero mask writes nothing and
  // must not mark the entry valid.
  assign rdAcc   = rd_en & ready & ~flush;
  assign wrAcc   = wr_en & ready & ~flush;
  assign wrApply = wrAcc & (|wr_mask);
  assign collide = rdAcc & wrAcc & (rd_addr == wr_addr);

  // One merged word serves both the array update and the write-first read
  // bypass, since on a collision both see the same old entry.
  assign wrMerged = DATA_WIDTH'(mergeLanes(BTB_MAX_DATA_WIDTH'(mem_q[wr_addr]),
                                           BTB_MAX_DATA_WIDTH'(wr_data),
                                           BTB_MAX_DATA_WIDTH'(wr_mask),
                                           LANE_WIDTH));

  assign rdData_d = collide ? wrMerged : mem_q[rd_addr];
  assign rdHit_d  = valid_q[rd_addr] | (collide & wrApply);

  // Entry storage is deliberately left unreset; only valid bits gate use.
  always_ff @(posedge clk) begin
    if (wrApply) begin
      mem_q[wr_addr] <= wrMerged;
    end
  end

  // Valid vector and read response registers. Clear and write never overlap
  // because writes are only accepted once the clear walk has finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdHit_q   <= 1'b0;
    end else begin
      rdValid_q <= rdAcc;
      if (rdAcc) begin
        rdData_q <= rdData_d;
        rdHit_q  <= rdHit_d;
      end
      if (clrEn) begin
        valid_q[clrAddr] <= 1'b0;
      end
      if (wrApply) begin
        valid_q[wr_addr] <= 1'b1;
      end
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign rd_hit   = rdHit_q;

endmodule

// File: tb/tb_btb_array.sv
// tb_btb_array
//   Directed bench for btb_array (default 56-bit x 16 entries, 8-bit lanes).
module tb_btb_array;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ready;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        rd_valid;
  logic [55:0] rd_data;
  logic        rd_hit;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [55:0] wr_data;
  logic [6:0]  wr_mask;

  int checkCount = 0;
  int passCount  = 0;

  btb_array dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mask (wr_mask)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of request inputs.
  task automatic applyStimulus(input logic rdEnV, input logic [3:0] rdAddrV,
                               input logic wrEnV, input logic [3:0] wrAddrV,
                               input logic [55:0] wrDataV, input logic [6:0] wrMaskV,
                               input logic flushV);
    rd_en   = rdEnV;
    rd_addr = rdAddrV;
    wr_en   = wrEnV;
    wr_addr = wrAddrV;
    wr_data = wrDataV;
    wr_mask = wrMaskV;
    flush   = flushV;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, required %h", tag, observed, expected);
  endtask

  // Fill pattern for the populate pass; entry 9 is kept zero for the collision case.
  function automatic logic [55:0] patt(input int a);
    logic [55:0] ones;
    ones = 56'h01_0101_0101_0101;
    if (a == 9) return 56'h0;
    return ones * 56'(a);
  endfunction

  initial begin
    int edges;
    int hits;
    int rdSeen;

    rst_n = 1'b0;
    idle();
    #22;
    checkOutput("rst_ready",    64'(ready),    64'h0);
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'h0);
    checkOutput("rst_rd_hit",   64'(rd_hit),   64'h0);
    checkOutput("rst_rd_data",  64'(rd_data),  64'h0);

    // Release mid-cycle; requests during the walk must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_ready", 64'(ready), 64'h0);
    edges  = 0;
    rdSeen = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 10) applyStimulus(1'b1, 4'd3, 1'b1, 4'd3, 56'hFF_FFFF_FFFF_FFFF, 7'h7F, 1'b0);
      else idle();
      step();
      if (rd_valid) rdSeen++;
      if (ready) begin
        edges = k;
        break;
      end
    end
    idle();
    checkOutput("clear_len_after_reset", 64'(edges), 64'd16);
    checkOutput("no_read_during_clear",  64'(rdSeen), 64'd0);

    // Read of an entry written only during the clear walk must miss.
    applyStimulus(1'b1, 4'd3, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("rd3_valid", 64'(rd_valid), 64'h1);
    checkOutput("rd3_hit",   64'(rd_hit),   64'h0);
    idle();
    step();
    checkOutput("rd_valid_pulse", 64'(rd_valid), 64'h0);

    // Full write then read.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 56'h12_3456_789A_BCDE, 7'h7F, 1'b0);
    step();
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("full_wr_data", 64'(rd_data), 64'h12_3456_789A_BCDE);
    checkOutput("full_wr_hit",  64'(rd_hit),  64'h1);

    // Lane 0 only.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 56'hFF_FFFF_FFFF_FFFF, 7'b0000001, 1'b0);
    step();
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("partial_wr_data", 64'(rd_data), 64'h12_3456_789A_BCFF);

    // Independent read and write in the same cycle, then read back the write.
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd6, 56'h11_2233_4455_6677, 7'h7F, 1'b0);
    step();
    checkOutput("indep_rd_data",  64'(rd_data),  64'h12_3456_789A_BCFF);
    checkOutput("indep_rd_valid", 64'(rd_valid), 64'h1);
    applyStimulus(1'b1, 4'd6, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("indep_wr_data", 64'(rd_data), 64'h11_2233_4455_6677);
    checkOutput("indep_wr_hit",  64'(rd_hit),  64'h1);

    // Zero mask must not set valid.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd7, 56'hFF_FFFF_FFFF_FFFF, 7'h00, 1'b0);
    step();
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("zero_mask_hit", 64'(rd_hit), 64'h0);

    // Populate every entry.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 4'(a), patt(a), 7'h7F, 1'b0);
      step();
    end

    // Read just before the flush keeps its pre-flush response.
    applyStimulus(1'b1, 4'd4, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("preflush_rd_hit",  64'(rd_hit),  64'h1);
    checkOutput("preflush_rd_data", 64'(rd_data), 64'(patt(4)));

    // Flush with a same-cycle write and read: both dropped.
    applyStimulus(1'b1, 4'd4, 1'b1, 4'd2, 56'hFF_FFFF_FFFF_FFFF, 7'h7F, 1'b1);
    step();
    checkOutput("flush_ready",    64'(ready),    64'h0);
    checkOutput("flush_rd_drop",  64'(rd_valid), 64'h0);
    idle();
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ready) begin
        edges = k;
        break;
      end
    end
    checkOutput("clear_len_after_flush", 64'(edges), 64'd16);

    hits = 0;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 4'(a), 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
      step();
      if (rd_hit) hits++;
      if (a == 2) checkOutput("flush_wr_dropped", 64'(rd_data), 64'(patt(2)));
    end
    checkOutput("postflush_hits", 64'(hits), 64'd0);

    // Write-first collision on an invalid zero entry.
    applyStimulus(1'b1, 4'd9, 1'b1, 4'd9, 56'hAA_AAAA_AAAA_AAAA, 7'b1100000, 1'b0);
    step();
    checkOutput("collide_data", 64'(rd_data), 64'hAA_AA00_0000_0000);
    checkOutput("collide_hit",  64'(rd_hit),  64'h1);

    // Collision with empty mask returns old contents and old valid.
    applyStimulus(1'b1, 4'd10, 1'b1, 4'd10, 56'hFF_FFFF_FFFF_FFFF, 7'h00, 1'b0);
    step();
    checkOutput("collide_nomask_data", 64'(rd_data), 64'(patt(10)));
    checkOutput("collide_nomask_hit",  64'(rd_hit),  64'h0);

    // Asynchronous reset with a response on the outputs.
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("prereset_rd_valid", 64'(rd_valid), 64'h1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ready",    64'(ready),    64'h0);
    checkOutput("async_rd_valid", 64'(rd_valid), 64'h0);
    checkOutput("async_rd_hit",   64'(rd_hit),   64'h0);

    // Flush at clear cycle 8 extends the walk to 25 cycles in total.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 56'h0, 7'h00, (k == 9));
      step();
      if (ready) begin
        edges = k;
        break;
      end
    end
    idle();
    checkOutput("clear_len_flush_in_clear", 64'(edges), 64'd25);

    // Storage survives reset, valid does not.
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd0, 56'h0, 7'h00, 1'b0);
    step();
    checkOutput("postreset_data", 64'(rd_data), 64'hAA_AA00_0000_0000);
    checkOutput("postreset_hit",  64'(rd_hit),  64'h0);
    idle();
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
